// File: rtl/alu_op_sequencer.sv
// Request/response front end for the combinational ALU: decodes ALUOp/funct,
// sequences operands and OP around a parked code, and returns the captured result.
module alu_op_sequencer #(
    parameter logic [3:0] PARK_OP = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  ALUOp,
    input  logic [5:0]  funct,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic [31:0] dato1,
    output logic [31:0] dato2,
    output logic [3:0]  OP,
    input  logic [31:0] datoOut,
    input  logic        ZF,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] resultado,
    output logic        zero,
    output logic        err,
    output logic [15:0] ops_done
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [OP_W-1:0]   code_q;
    logic [OP_W-1:0]   code_c;
    logic              illegal_c;
    logic              accept_c;
    logic              capture_c;
    logic              complete_c;

    // Request decode to the ALU operation code
    always_comb begin
        code_c    = OP_W'(4'b0010);
        illegal_c = 1'b0;
        unique case (ALUOp)
            2'b00: code_c = OP_W'(4'b0010);
            2'b01: code_c = OP_W'(4'b0110);
            2'b10: begin
                unique case (funct)
                    6'b100100: code_c = OP_W'(4'b0000);
                    6'b100101: code_c = OP_W'(4'b0001);
                    6'b100000: code_c = OP_W'(4'b0010);
                    6'b100010: code_c = OP_W'(4'b0110);
                    6'b101010: code_c = OP_W'(4'b0111);
                    6'b100111: code_c = OP_W'(4'b1100);
                    default:   illegal_c = 1'b1;
                endcase
            end
            default: illegal_c = 1'b1;
        endcase
    end

    // Next-state and handshake strobes
    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        capture_c  = 1'b0;
        complete_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_d  = illegal_c ? RESP : SETUP;
                end
            end
            SETUP: state_d = EXEC;
            EXEC: begin
                capture_c = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                if (out_ready) begin
                    complete_c = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs; OP only leaves PARK_OP for the EXEC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q    <= PARK_OP;
            dato1     <= '0;
            dato2     <= '0;
            OP        <= PARK_OP;
            resultado <= '0;
            zero      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            ops_done  <= '0;
        end else begin
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == RESP);
            OP        <= (state_d == EXEC) ? code_q : PARK_OP;
            if (accept_c) begin
                code_q <= code_c;
                if (illegal_c) begin
                    resultado <= '0;
                    zero      <= 1'b1;
                    err       <= 1'b1;
                end else begin
                    dato1 <= opA;
                    dato2 <= opB;
                end
            end
            if (capture_c) begin
                resultado <= DATA_W'(datoOut);
                zero      <= ~ZF;
                err       <= 1'b0;
            end
            if (complete_c && (ops_done != {CNT_W{1'b1}})) begin
                ops_done <= ops_done + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: event-driven ALU model, directed vector table,
// multi-cycle corner sequences and randomized requests against a reference model.
module tb_alu_op_sequencer;

    localparam logic [3:0] PARK = 4'b1111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  ALUOp = 2'b00;
    logic [5:0]  funct = 6'd0;
    logic [31:0] opA = 32'd0;
    logic [31:0] opB = 32'd0;
    logic [31:0] dato1;
    logic [31:0] dato2;
    logic [3:0]  OP;
    logic [31:0] datoOut;
    logic        ZF;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] resultado;
    logic        zero;
    logic        err;
    logic [15:0] ops_done;

    int checks = 0;
    int errors = 0;
    int exp_ops = 0;

    alu_op_sequencer #(.PARK_OP(PARK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .funct(funct), .opA(opA), .opB(opB),
        .dato1(dato1), .dato2(dato2), .OP(OP), .datoOut(datoOut), .ZF(ZF),
        .out_valid(out_valid), .out_ready(out_ready), .resultado(resultado),
        .zero(zero), .err(err), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        case (code)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return (a < b) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    // External ALU: re-evaluates only when OP changes
    logic [31:0] alu_res = 32'd0;
    always @(OP) alu_res = alu_fn(OP, dato1, dato2);
    assign datoOut = alu_res;
    assign ZF = (alu_res != 32'd0);

    typedef struct packed {
        logic        err;
        logic [3:0]  code;
        logic [31:0] res;
    } ref_t;

    function automatic ref_t ref_op(input logic [1:0] aluop, input logic [5:0] f,
                                    input logic [31:0] a, input logic [31:0] b);
        ref_t r;
        r.err = 1'b0;
        r.code = 4'b0010;
        if (aluop == 2'b01) r.code = 4'b0110;
        else if (aluop == 2'b11) r.err = 1'b1;
        else if (aluop == 2'b10) begin
            if (f == 6'h24) r.code = 4'b0000;
            else if (f == 6'h25) r.code = 4'b0001;
            else if (f == 6'h20) r.code = 4'b0010;
            else if (f == 6'h22) r.code = 4'b0110;
            else if (f == 6'h2A) r.code = 4'b0111;
            else if (f == 6'h27) r.code = 4'b1100;
            else r.err = 1'b1;
        end
        r.res = r.err ? 32'd0 : alu_fn(r.code, a, b);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // OP must never jump between codes and needs >=2 parked cycles before each code
    logic [3:0] prev_op = PARK;
    int park_run = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (OP != prev_op) begin
                if (prev_op != PARK) check("op_direct_switch", 32'(OP), 32'(PARK));
                else check("op_park_gap", 32'(park_run >= 2), 32'd1);
            end
            park_run = (OP == PARK) ? park_run + 1 : 0;
            prev_op = OP;
        end else begin
            park_run = 2;
            prev_op = PARK;
        end
    end

    task automatic run_op(input logic [1:0] aluop, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int hold, input logic use_exp,
                          input logic [31:0] exp_res, input logic exp_zero, input logic exp_err);
        ref_t r;
        int lat;
        int waitc;
        logic [31:0] d1, d2, res0;
        logic z0, e0;
        r = ref_op(aluop, f, a, b);
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(posedge clk); #1; waitc++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        d1 = dato1;
        d2 = dato2;
        ALUOp = aluop; funct = f; opA = a; opB = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; opA = $urandom; opB = $urandom;
        lat = 1;
        while (!out_valid && lat < 10) begin
            if (lat == 1) begin
                check("setup_op_parked", 32'(OP), 32'(PARK));
                check("setup_dato1", dato1, a);
                check("setup_dato2", dato2, b);
                out_ready = 1'b1;
            end
            if (lat == 2) begin
                check("exec_op_code", 32'(OP), 32'(r.code));
                out_ready = 1'b0;
            end
            @(posedge clk); #1; lat++;
        end
        out_ready = 1'b0;
        check("latency", 32'(lat), r.err ? 32'd1 : 32'd3);
        check("out_valid", 32'(out_valid), 32'd1);
        check("resultado", resultado, r.res);
        check("zero", 32'(zero), 32'(r.res == 32'd0));
        check("err", 32'(err), 32'(r.err));
        check("resp_op_parked", 32'(OP), 32'(PARK));
        if (use_exp) begin
            check("vec_resultado", resultado, exp_res);
            check("vec_zero", 32'(zero), 32'(exp_zero));
            check("vec_err", 32'(err), 32'(exp_err));
        end
        if (r.err) begin
            check("illegal_dato1_kept", dato1, d1);
            check("illegal_dato2_kept", dato2, d2);
        end
        res0 = resultado; z0 = zero; e0 = err;
        for (int i = 0; i < hold; i++) begin
            in_valid = ((i % 2) == 0);
            ALUOp = 2'b00;
            check("resp_in_ready_low", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_resultado", resultado, res0);
            check("hold_zero", 32'(zero), 32'(z0));
            check("hold_err", 32'(err), 32'(e0));
            check("hold_ops_done", 32'(ops_done), 32'(exp_ops));
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        if (exp_ops < 65535) exp_ops++;
        check("done_out_valid_low", 32'(out_valid), 32'd0);
        check("done_in_ready", 32'(in_ready), 32'd1);
        check("ops_done", 32'(ops_done), 32'(exp_ops));
    endtask

    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        logic [31:0] res;
        logic        z;
        logic        e;
    } vec_t;

    vec_t vecs[13];
    logic [5:0] legal_f[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{2'b10, 6'h20, 32'd5, 32'd7, 0, 32'd12, 1'b0, 1'b0};
        vecs[1]  = '{2'b01, 6'h00, 32'd9, 32'd9, 0, 32'd0, 1'b1, 1'b0};
        vecs[2]  = '{2'b01, 6'h00, 32'd10, 32'd3, 0, 32'd7, 1'b0, 1'b0};
        vecs[3]  = '{2'b11, 6'h20, 32'd1, 32'd2, 1, 32'd0, 1'b1, 1'b1};
        vecs[4]  = '{2'b10, 6'h2A, 32'd3, 32'd8, 5, 32'd1, 1'b0, 1'b0};
        vecs[5]  = '{2'b10, 6'h24, 32'h0000F0F0, 32'h0000FF00, 0, 32'h0000F000, 1'b0, 1'b0};
        vecs[6]  = '{2'b10, 6'h25, 32'h0000F0F0, 32'h00000F0F, 2, 32'h0000FFFF, 1'b0, 1'b0};
        vecs[7]  = '{2'b10, 6'h27, 32'd0, 32'd0, 0, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[8]  = '{2'b00, 6'h3F, 32'hFFFFFFFF, 32'd1, 0, 32'd0, 1'b1, 1'b0};
        vecs[9]  = '{2'b10, 6'h3F, 32'd1, 32'd1, 3, 32'd0, 1'b1, 1'b1};
        vecs[10] = '{2'b10, 6'h2A, 32'd8, 32'd3, 0, 32'd0, 1'b1, 1'b0};
        vecs[11] = '{2'b10, 6'h22, 32'd3, 32'd5, 0, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[12] = '{2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1, 1, 32'd0, 1'b1, 1'b0};
        legal_f[0] = 6'h24; legal_f[1] = 6'h25; legal_f[2] = 6'h20;
        legal_f[3] = 6'h22; legal_f[4] = 6'h2A; legal_f[5] = 6'h27;

        // Reset state
        #22;
        check("rst_op", 32'(OP), 32'(PARK));
        check("rst_dato1", dato1, 32'd0);
        check("rst_dato2", dato2, 32'd0);
        check("rst_resultado", resultado, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ops_done", 32'(ops_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].aluop, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].hold,
                   1'b1, vecs[i].res, vecs[i].z, vecs[i].e);
        end

        // Reset asserted during EXEC aborts the operation
        ALUOp = 2'b00; opA = 32'd40; opB = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_exec_op", 32'(OP), 32'b0010);
        rst_n = 1'b0;
        #1;
        check("abort_op", 32'(OP), 32'(PARK));
        check("abort_dato1", dato1, 32'd0);
        check("abort_resultado", resultado, 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_ops_done", 32'(ops_done), 32'd0);
        exp_ops = 0;
        @(posedge clk); #1;
        check("abort_held_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'b10, 6'h20, 32'd100, 32'd23, 0, 1'b1, 32'd123, 1'b0, 1'b0);

        // Randomized requests against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ao;
            logic [5:0]  fx;
            logic [31:0] a, b;
            int k;
            ao = 2'($urandom_range(0, 3));
            k = $urandom_range(0, 6);
            fx = (k == 6) ? 6'($urandom) : legal_f[k];
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : 32'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            run_op(ao, fx, a, b, $urandom_range(0, 3), 1'b0, 32'd0, 1'b0, 1'b0);
        end

        // Saturation of the completion counter
        dut.ops_done = 16'hFFFE;
        exp_ops = 65534;
        #1;
        for (int i = 0; i < 3; i++) begin
            run_op(2'b00, 6'h00, 32'(i), 32'd1, 0, 1'b0, 32'd0, 1'b0, 1'b0);
        end
        check("ops_done_saturated", 32'(ops_done), 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
